ram32x3_sequencer: RTL and testbench
====================================

# ram32x3_sequencer

Master-side controller for the 32x3 dual-port RAM wrapper with registered addresses. It clears all 32 words after reset, then continuously scans read addresses 0..31 at a programmable rate and returns each word tagged with its address. In parallel it accepts single-word write requests over a req/ack handshake. It drives the RAM wrapper's datain/rdaddress/wraddress/wren and consumes its dataout.

## Interface
- SCAN_DIV, 4: clock cycles per read issue; must be >= 1.
- RD_LAT, 2: edges from a registered ram_rdaddress change to valid ram_dataout; covers the wrapper address register plus RAM port; must be >= 1.
- CLEAR_VAL, 3'b000: value written to every word during the clear phase.

- clock  in  1  clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  scan enable; when low, read issue freezes.
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_ack.
- wr_addr  in  5  write address.
- wr_data  in  3  write data.
- wr_ack  out  1  one-cycle pulse; the write has been issued to the RAM.
- ram_rdaddress  out  5  RAM read address (registered).
- ram_wraddress  out  5  RAM write address (registered).
- ram_wren  out  1  RAM write enable (registered).
- ram_datain  out  3  RAM write data (registered).
- ram_dataout  in  3  RAM read data.
- rd_valid  out  1  rd_addr/rd_data are valid this cycle.
- rd_addr  out  5  address of the returned word.
- rd_data  out  3  returned word.
- init_done  out  1  clear phase complete.

## Operation
- **States:**
  - CLEAR is entered on reset.
  - SCAN is entered after the clear phase and holds until reset.
- **CLEAR:**
  - Each cycle drive ram_wren=1, ram_wraddress=clr_addr, ram_datain=CLEAR_VAL.
  - clr_addr runs 0..31.
  - After address 31: go to SCAN, ram_wren=0, init_done=1.
  - enable is ignored. wr_req is not acknowledged.
- **SCAN, read side:**
  - The divider counts only while enable=1.
  - At the edge where div==SCAN_DIV-1: ram_rdaddress<=scan_addr, scan_addr<=scan_addr+1 (31 wraps to 0), div<=0.
  - When enable=0, div and scan_addr hold.
- **Return pipeline:**
  - An RD_LAT-deep valid+address shift register is loaded on each read issue.
  - At its output, register rd_valid=1, rd_addr=tag, rd_data=ram_dataout.
  - The pipeline always advances, regardless of enable, so in-flight reads still return.
- **SCAN, write side:**
  - If wr_req=1 and wr_ack=0: register ram_wren=1, ram_wraddress=wr_addr, ram_datain=wr_data, wr_ack=1.
  - The next cycle: ram_wren=0, wr_ack=0.
  - A request held high is therefore serviced at most every other cycle.
- **Simultaneous read issue and accepted write:**
  - Both proceed on their separate ports.
  - Exception: if the addresses are equal, the read issue slips one cycle (div and scan_addr hold), so the returned data is the newly written value.
- **Reset mid-operation:** discards pending reads and any in-progress write, and restarts CLEAR at address 0.

## Timing
- **Values while reset is high and after the edge that samples it:**
  - ram_wren=0, ram_wraddress=0, ram_rdaddress=0, ram_datain=0.
  - wr_ack=0, rd_valid=0, rd_addr=0, rd_data=0, init_done=0.
  - div=0, scan_addr=0, pipeline empty.
- **Clear phase:**
  - Edge k (k=0..31) after the first reset-low edge presents clear write address k.
  - Edge 32 deasserts ram_wren and asserts init_done.
  - Total clear time is 33 cycles.
- **First read (enable=1):** issued at the SCAN_DIV-th edge after entering SCAN.
- **Read latency:** rd_valid for a read issued at edge n is seen after edge n+RD_LAT+1 (one extra output register).
- **wr_ack:** follows the edge sampling wr_req by one register stage; the RAM write occurs on the next edge.
- **rd_valid:** never asserted during CLEAR.

## Test plan
- Reset, hold enable=0 → exactly 32 consecutive wren cycles, addresses 0..31, data 3'b000; init_done=1 at cycle 33; no rd_valid.
- Clear, SCAN_DIV=4, enable=1 for 140 cycles → rd_valid every 4 cycles; rd_addr 0,1,...,31,0 with wrap; all rd_data=0.
- After clear, wr_req with addr 5 / data 3'b101 held until ack → single wr_ack pulse, single wren cycle at address 5; next scan of address 5 returns 3'b101, others return 0.
- Collision: time the write so it lands on the same cycle as a read issue to the same address (addr 9, data 3'b011) → read slips one cycle; rd_addr=9 returns 3'b011.
- Toggle enable low for 10 cycles mid-scan → no new read issues; in-flight reads still produce rd_valid; scan resumes at the next address without skipping.
- Assert reset for 1 cycle mid-scan with a write pending → outputs return to reset values; clear restarts at address 0; the pending write is not acknowledged.

Source files
------------

// File: rtl/ram32x3_sequencer.sv
// ram32x3_sequencer: master-side controller for a 32x3 dual-port RAM wrapper.
// After reset it writes CLEAR_VAL into all 32 words. It then scans read
// addresses 0..31 at one read every SCAN_DIV enabled cycles and returns each
// word tagged with its address. Single-word writes arrive over a req/ack
// handshake and use the write port alongside the scan.
module ram32x3_sequencer #(
  parameter int unsigned SCAN_DIV  = 4,
  parameter int unsigned RD_LAT    = 2,
  parameter logic [2:0]  CLEAR_VAL = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_req,
  input  logic [4:0] wr_addr,
  input  logic [2:0] wr_data,
  output logic       wr_ack,
  output logic [4:0] ram_rdaddress,
  output logic [4:0] ram_wraddress,
  output logic       ram_wren,
  output logic [2:0] ram_datain,
  input  logic [2:0] ram_dataout,
  output logic       rd_valid,
  output logic [4:0] rd_addr,
  output logic [2:0] rd_data,
  output logic       init_done
);

  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {CLEAR, SCAN} state_t;

  state_t           state_q;
  logic [5:0]       clrAddr_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       scanAddr_q, scanAddr_d;

  // Valid bits and address tags for reads still travelling through the RAM.
  // One stage more than RD_LAT so the output register samples ram_dataout
  // one edge after it becomes valid.
  logic [RD_LAT:0]  pipeValid_q;
  logic [4:0]       pipeTag_q [0:RD_LAT];

  logic       wrAck_q;
  logic [4:0] ramRdAddr_q;
  logic [4:0] ramWrAddr_q;
  logic       ramWren_q;
  logic [2:0] ramDatain_q;
  logic       rdValid_q;
  logic [4:0] rdAddr_q;
  logic [2:0] rdData_q;
  logic       initDone_q;

  logic wrAccept;
  logic readSlot;
  logic readSlip;
  logic issueRead;

  // Decide this cycle's write acceptance and read issue. A read slips one
  // cycle when it would target the same word as a write accepted on the same
  // edge, so the scan returns the freshly written value.
  always_comb begin
    wrAccept   = (state_q == SCAN) && wr_req && !wrAck_q;
    readSlot   = (state_q == SCAN) && enable && (div_q == DIV_LAST);
    readSlip   = wrAccept && (wr_addr == scanAddr_q);
    issueRead  = readSlot && !readSlip;
    div_d      = div_q;
    scanAddr_d = scanAddr_q;
    if ((state_q == SCAN) && enable) begin
      if (issueRead) begin
        div_d      = '0;
        scanAddr_d = scanAddr_q + 5'd1;
      end else if (!readSlot) begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Controller FSM, clear/scan counters, return pipeline and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= CLEAR;
      clrAddr_q   <= '0;
      div_q       <= '0;
      scanAddr_q  <= '0;
      pipeValid_q <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        pipeTag_q[i] <= '0;
      end
      wrAck_q     <= 1'b0;
      ramRdAddr_q <= '0;
      ramWrAddr_q <= '0;
      ramWren_q   <= 1'b0;
      ramDatain_q <= '0;
      rdValid_q   <= 1'b0;
      rdAddr_q    <= '0;
      rdData_q    <= '0;
      initDone_q  <= 1'b0;
    end else begin
      pipeValid_q  <= {pipeValid_q[RD_LAT-1:0], issueRead};
      pipeTag_q[0] <= scanAddr_q;
      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        pipeTag_q[i] <= pipeTag_q[i-1];
      end
      rdValid_q <= pipeValid_q[RD_LAT];
      if (pipeValid_q[RD_LAT]) begin
        rdAddr_q <= pipeTag_q[RD_LAT];
        rdData_q <= ram_dataout;
      end

      case (state_q)
        CLEAR: begin
          if (clrAddr_q[5]) begin
            ramWren_q  <= 1'b0;
            initDone_q <= 1'b1;
            state_q    <= SCAN;
          end else begin
            ramWren_q   <= 1'b1;
            ramWrAddr_q <= clrAddr_q[4:0];
            ramDatain_q <= CLEAR_VAL;
            clrAddr_q   <= clrAddr_q + 6'd1;
          end
        end
        SCAN: begin
          div_q      <= div_d;
          scanAddr_q <= scanAddr_d;
          if (issueRead) begin
            ramRdAddr_q <= scanAddr_q;
          end
          ramWren_q <= wrAccept;
          wrAck_q   <= wrAccept;
          if (wrAccept) begin
            ramWrAddr_q <= wr_addr;
            ramDatain_q <= wr_data;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign wr_ack        = wrAck_q;
  assign ram_rdaddress = ramRdAddr_q;
  assign ram_wraddress = ramWrAddr_q;
  assign ram_wren      = ramWren_q;
  assign ram_datain    = ramDatain_q;
  assign rd_valid      = rdValid_q;
  assign rd_addr       = rdAddr_q;
  assign rd_data       = rdData_q;
  assign init_done     = initDone_q;

endmodule

// File: tb/tb_ram32x3_sequencer.sv
// tb_ram32x3_sequencer: drives ram32x3_sequencer against a model of the RAM
// wrapper. The expected outputs come from a transaction-level reference model
// that runs on each rising edge. Directed scenarios pin exact timing values.
// A randomized phase mixes enable toggling, write traffic and a reset.
module tb_ram32x3_sequencer;

  localparam int         SCAN_DIV  = 4;
  localparam int         RD_LAT    = 2;
  localparam logic [2:0] CLEAR_VAL = 3'b000;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       wr_req;
  logic [4:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_ack;
  logic [4:0] ram_rdaddress;
  logic [4:0] ram_wraddress;
  logic       ram_wren;
  logic [2:0] ram_datain;
  logic [2:0] ram_dataout;
  logic       rd_valid;
  logic [4:0] rd_addr;
  logic [2:0] rd_data;
  logic       init_done;

  int assertCount = 0;
  int failCount   = 0;

  ram32x3_sequencer #(
    .SCAN_DIV (SCAN_DIV),
    .RD_LAT   (RD_LAT),
    .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .ram_rdaddress(ram_rdaddress),
    .ram_wraddress(ram_wraddress),
    .ram_wren     (ram_wren),
    .ram_datain   (ram_datain),
    .ram_dataout  (ram_dataout),
    .rd_valid     (rd_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .init_done    (init_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // RAM wrapper: the read address is registered, then the RAM output is registered.
  // The memory starts with non-zero contents, so a missing clear shows up.
  logic [2:0] ramMem [32];
  logic [4:0] ramAddrReg = '0;
  bit         ramSeeded  = 1'b0;
  always @(posedge clock) begin
    if (!ramSeeded) begin
      for (int i = 0; i < 32; i++) ramMem[i] <= 3'(i % 7 + 1);
      ramSeeded <= 1'b1;
    end else if (ram_wren) begin
      ramMem[ram_wraddress] <= ram_datain;
    end
    ramAddrReg  <= ram_rdaddress;
    ram_dataout <= ramMem[ramAddrReg];
  end

  // Reference model. It counts edges since reset. It keeps the logical memory contents
  // and a queue of issued reads, each with the edge index of its due return.
  typedef struct {
    int         due;
    logic [4:0] addr;
    logic [2:0] data;
  } readRec_t;

  readRec_t   readQ [$];
  logic [2:0] modelMem [32];
  int         cyc = 0;
  int         mDiv = 0;
  int         mScan = 0;
  bit         modelReady = 1'b0;
  bit         expWren, expWrAck, expRdValid, expInitDone;
  logic [4:0] expWraddr, expRdaddr, expRdAddr;
  logic [2:0] expDatain, expRdData;

  always @(posedge clock) begin : refModel
    int k;
    bit accept;
    if (reset) begin
      cyc = 0; mDiv = 0; mScan = 0;
      readQ.delete();
      expWren = 0; expWrAck = 0; expRdValid = 0; expInitDone = 0;
      expWraddr = 0; expRdaddr = 0; expRdAddr = 0; expDatain = 0; expRdData = 0;
      modelReady = 1'b1;
    end else if (modelReady) begin
      k = cyc;
      cyc++;
      expRdValid = 0;
      if (readQ.size() > 0 && readQ[0].due == k) begin
        expRdValid = 1;
        expRdAddr  = readQ[0].addr;
        expRdData  = readQ[0].data;
        readQ.delete(0);
      end
      if (k < 32) begin
        expWren     = 1;
        expWraddr   = k[4:0];
        expDatain   = CLEAR_VAL;
        modelMem[k] = CLEAR_VAL;
        expWrAck    = 0;
      end else if (k == 32) begin
        expWren     = 0;
        expWrAck    = 0;
        expInitDone = 1;
      end else begin
        accept  = wr_req && !expWrAck;
        expWren = accept;
        if (accept) begin
          expWraddr         = wr_addr;
          expDatain         = wr_data;
          modelMem[wr_addr] = wr_data;
        end
        if (enable) begin
          if (mDiv == SCAN_DIV - 1) begin
            if (!(accept && wr_addr == mScan[4:0])) begin
              expRdaddr = mScan[4:0];
              readQ.push_back('{due: k + RD_LAT + 1, addr: mScan[4:0], data: modelMem[mScan]});
              mScan = (mScan + 1) % 32;
              mDiv  = 0;
            end
          end else begin
            mDiv++;
          end
        end
        expWrAck = accept;
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clock) begin
    if (modelReady) begin
      checkOutput("wr_ack", int'(wr_ack), int'(expWrAck));
      checkOutput("ram_wren", int'(ram_wren), int'(expWren));
      checkOutput("init_done", int'(init_done), int'(expInitDone));
      checkOutput("rd_valid", int'(rd_valid), int'(expRdValid));
      checkOutput("ram_rdaddress", int'(ram_rdaddress), int'(expRdaddr));
      if (expWren || cyc == 0) begin
        checkOutput("ram_wraddress", int'(ram_wraddress), int'(expWraddr));
        checkOutput("ram_datain", int'(ram_datain), int'(expDatain));
      end
      if (expRdValid || cyc == 0) begin
        checkOutput("rd_addr", int'(rd_addr), int'(expRdAddr));
        checkOutput("rd_data", int'(rd_data), int'(expRdData));
      end
    end
  end

  // Returned addresses must step by one with wrap and no skips. Each scan
  // after a clear starts at address 0.
  int lastRdAddr = 0;
  bit haveLast   = 1'b0;
  always @(negedge clock) begin
    if (!expInitDone) begin
      haveLast = 1'b0;
    end else if (rd_valid) begin
      if (haveLast) checkOutput("rd_sequence", int'(rd_addr), (lastRdAddr + 1) % 32);
      else          checkOutput("rd_first_addr", int'(rd_addr), 0);
      lastRdAddr = int'(rd_addr);
      haveLast   = 1'b1;
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin : applyStimulus
    int         wrenCount;
    int         rdCount;
    int         ackCount;
    int         e;
    int         lastEdge;
    bit         found;
    logic [4:0] heldAddr;

    reset = 1; enable = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
    repeat (3) @(negedge clock);
    checkOutput("reset_wren", int'(ram_wren), 0);
    checkOutput("reset_wraddress", int'(ram_wraddress), 0);
    checkOutput("reset_rdaddress", int'(ram_rdaddress), 0);
    checkOutput("reset_datain", int'(ram_datain), 0);
    checkOutput("reset_wr_ack", int'(wr_ack), 0);
    checkOutput("reset_rd_valid", int'(rd_valid), 0);
    checkOutput("reset_init_done", int'(init_done), 0);

    // Clear phase with the scan disabled.
    reset = 0;
    wrenCount = 0; rdCount = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clock);
      if (ram_wren) wrenCount++;
      if (rd_valid) rdCount++;
      if (c == 0) checkOutput("clear_first_addr", int'(ram_wraddress), 0);
      if (c == 31) begin
        checkOutput("clear_last_addr", int'(ram_wraddress), 31);
        checkOutput("init_done_early", int'(init_done), 0);
      end
      if (c == 32) begin
        checkOutput("init_done_edge32", int'(init_done), 1);
        checkOutput("wren_off_edge32", int'(ram_wren), 0);
      end
    end
    checkOutput("clear_wren_count", wrenCount, 32);
    repeat (10) begin
      @(negedge clock);
      if (rd_valid) rdCount++;
    end
    checkOutput("no_read_when_disabled", rdCount, 0);

    // Fresh clear with enable high, then a continuous scan.
    reset = 1; enable = 1;
    @(negedge clock);
    reset = 0;
    e = 0;
    while (!rd_valid && e < 100) begin
      @(negedge clock);
      e++;
    end
    checkOutput("first_read_edge", e - 1, 39);
    checkOutput("first_read_valid", int'(rd_valid), 1);
    lastEdge = e; rdCount = 1;
    for (int c = 0; c < 140; c++) begin
      @(negedge clock);
      e++;
      if (rd_valid) begin
        checkOutput("scan_gap", e - lastEdge, SCAN_DIV);
        checkOutput("scan_data_cleared", int'(rd_data), int'(CLEAR_VAL));
        lastEdge = e;
        rdCount++;
      end
    end
    checkOutput("scan_read_count", rdCount, 36);

    // Single write held until acknowledged.
    wr_addr = 5; wr_data = 3'b101; wr_req = 1;
    ackCount = 0; wrenCount = 0; e = 0;
    while (ackCount == 0 && e < 20) begin
      @(negedge clock);
      e++;
      if (wr_ack) ackCount++;
      if (ram_wren) begin
        wrenCount++;
        checkOutput("write_addr", int'(ram_wraddress), 5);
        checkOutput("write_data", int'(ram_datain), 5);
      end
    end
    wr_req = 0;
    repeat (4) begin
      @(negedge clock);
      if (wr_ack) ackCount++;
      if (ram_wren) wrenCount++;
    end
    checkOutput("write_ack_pulses", ackCount, 1);
    checkOutput("write_wren_cycles", wrenCount, 1);
    e = 0; found = 0;
    while (!found && e < 200) begin
      @(negedge clock);
      e++;
      if (rd_valid && rd_addr == 5'd5) found = 1;
    end
    checkOutput("readback5_seen", int'(found), 1);
    checkOutput("readback5_data", int'(rd_data), 5);

    // Write accepted on the same edge as the read issue to address 9.
    e = 0; found = 0;
    while (!found && e < 300) begin
      @(negedge clock);
      e++;
      if (mScan == 9 && mDiv == SCAN_DIV - 1 && !expWrAck) found = 1;
    end
    checkOutput("collision_setup", int'(found), 1);
    wr_addr = 9; wr_data = 3'b011; wr_req = 1;
    @(negedge clock);
    checkOutput("collision_ack", int'(wr_ack), 1);
    checkOutput("collision_slip_hold", int'(ram_rdaddress), 8);
    wr_req = 0;
    @(negedge clock);
    checkOutput("collision_slip_issue", int'(ram_rdaddress), 9);
    e = 0; found = 0;
    while (!found && e < 10) begin
      @(negedge clock);
      e++;
      if (rd_valid && rd_addr == 5'd9) found = 1;
    end
    checkOutput("collision_seen", int'(found), 1);
    checkOutput("collision_data", int'(rd_data), 3);

    // Freeze the scan just after a read issue; the in-flight read must still return.
    heldAddr = ram_rdaddress; e = 0;
    while (ram_rdaddress == heldAddr && e < 20) begin
      @(negedge clock);
      e++;
    end
    heldAddr = ram_rdaddress;
    enable = 0; rdCount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checkOutput("freeze_rdaddress", int'(ram_rdaddress), int'(heldAddr));
      if (rd_valid) begin
        rdCount++;
        checkOutput("freeze_inflight_addr", int'(rd_addr), int'(heldAddr));
      end
    end
    checkOutput("freeze_inflight_count", rdCount, 1);
    enable = 1;
    repeat (20) @(negedge clock);

    // Reset with a write pending: the clear restarts and the write waits.
    wr_addr = 20; wr_data = 3'b111; wr_req = 1; reset = 1;
    @(negedge clock);
    checkOutput("midreset_wr_ack", int'(wr_ack), 0);
    checkOutput("midreset_wren", int'(ram_wren), 0);
    checkOutput("midreset_rd_valid", int'(rd_valid), 0);
    checkOutput("midreset_init_done", int'(init_done), 0);
    checkOutput("midreset_rdaddress", int'(ram_rdaddress), 0);
    checkOutput("midreset_wraddress", int'(ram_wraddress), 0);
    reset = 0;
    ackCount = 0;
    for (int c = 0; c < 33; c++) begin
      @(negedge clock);
      if (wr_ack) ackCount++;
      if (c == 0) begin
        checkOutput("restart_wren", int'(ram_wren), 1);
        checkOutput("restart_addr", int'(ram_wraddress), 0);
      end
    end
    checkOutput("clear_blocks_write", ackCount, 0);
    e = 0;
    while (!wr_ack && e < 10) begin
      @(negedge clock);
      e++;
    end
    checkOutput("post_clear_ack", int'(wr_ack), 1);
    wr_req = 0;

    // Randomized traffic with one reset in the middle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clock);
      enable = ($urandom_range(0, 9) != 0);
      reset  = (c == 1000);
      if (wr_req && wr_ack) begin
        if ($urandom_range(0, 3) == 0) begin
          wr_addr = 5'($urandom_range(0, 31));
          wr_data = 3'($urandom_range(0, 7));
        end else begin
          wr_req = 0;
        end
      end else if (!wr_req && $urandom_range(0, 5) == 0) begin
        wr_req  = 1;
        wr_addr = 5'($urandom_range(0, 31));
        wr_data = 3'($urandom_range(0, 7));
      end
    end
    reset = 0; wr_req = 0;
    repeat (10) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
